// File: rtl/tnn_popcount_sched.sv
`default_nettype none
// ============================================================================
// Module      : tnn_popcount_sched
// Description : Time-shares one popcount unit among NUM_REQ ternary-neuron
//               requesters. Each job counts the positive-weight vector, then
//               the negative-weight vector. It forms diff = pos - neg and
//               thresholds diff into a ternary activation.
//               Optional macro TNN_SCHED_ERRSTAT_EN accumulates the absolute
//               error of the popcount unit against an exact internal count.
// Revision    : 1.0  initial release
// ============================================================================
module tnn_popcount_sched #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 29,
    parameter int CNT_W   = 5,
    parameter int THR_W   = 5,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*IN_W-1:0]   req_pos,
    input  logic [NUM_REQ*IN_W-1:0]   req_neg,
    input  logic [NUM_REQ*THR_W-1:0]  req_thr,
    output logic [IN_W-1:0]           pc_in,
    input  logic [CNT_W-1:0]          pc_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic signed [CNT_W:0]     rsp_diff,
    output logic [1:0]                rsp_act,
    output logic [15:0]               err_acc
);

    localparam int CMP_W = ((CNT_W > THR_W) ? CNT_W : THR_W) + 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POS  = 3'd1,
        ST_NEG  = 3'd2,
        ST_CMP  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ID_W-1:0]          rr_ptr;
    logic [ID_W-1:0]          gnt_idx;
    logic [ID_W-1:0]          cand;
    logic                     gnt_found;
    logic [IN_W-1:0]          pos_arr [NUM_REQ];
    logic [IN_W-1:0]          neg_arr [NUM_REQ];
    logic [THR_W-1:0]         thr_arr [NUM_REQ];
    logic [IN_W-1:0]          neg_q;
    logic [THR_W-1:0]         thr_q;
    logic [ID_W-1:0]          id_q;
    logic [CNT_W-1:0]         pos_cnt;
    logic [CNT_W-1:0]         neg_cnt;
    logic signed [CNT_W:0]    diff;
    logic signed [CMP_W-1:0]  diff_x;
    logic signed [CMP_W-1:0]  thr_x;
    logic [1:0]               act;

    // Split the flat operand buses into per-requester slices
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign pos_arr[gi] = req_pos[gi*IN_W +: IN_W];
            assign neg_arr[gi] = req_neg[gi*IN_W +: IN_W];
            assign thr_arr[gi] = req_thr[gi*THR_W +: THR_W];
        end
    endgenerate

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the one-cycle grant pulse
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_nxt          = ST_POS;
                end
            end
            ST_POS:  state_nxt = ST_NEG;
            ST_NEG:  state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Signed difference and ternary threshold; widened so -thr cannot overflow
    always_comb begin
        diff   = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
        diff_x = CMP_W'(diff);
        thr_x  = CMP_W'(thr_q);
        if (diff_x >= thr_x) begin
            act = 2'b01;
        end else if (diff_x <= -thr_x) begin
            act = 2'b11;
        end else begin
            act = 2'b00;
        end
    end

    // Job datapath: operand capture, popcount sampling, response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            pc_in     <= '0;
            neg_q     <= '0;
            thr_q     <= '0;
            id_q      <= '0;
            pos_cnt   <= '0;
            neg_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_diff  <= '0;
            rsp_act   <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        pc_in  <= pos_arr[gnt_idx];
                        neg_q  <= neg_arr[gnt_idx];
                        thr_q  <= thr_arr[gnt_idx];
                        id_q   <= gnt_idx;
                        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    end
                end
                ST_POS: begin
                    pos_cnt <= pc_out;
                    pc_in   <= neg_q;
                end
                ST_NEG: begin
                    neg_cnt <= pc_out;
                end
                ST_CMP: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_diff  <= diff;
                    rsp_act   <= act;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TNN_SCHED_ERRSTAT_EN
    localparam int EX_W = $clog2(IN_W + 1);
    localparam int AB_W = (EX_W > CNT_W) ? EX_W : CNT_W;

    logic [AB_W-1:0] exact;
    logic [AB_W-1:0] approx;
    logic [AB_W-1:0] abs_err;
    logic [16:0]     err_sum;
    logic [15:0]     err_q;

    // Exact reference count of the operand currently presented to the unit
    always_comb begin
        exact = '0;
        for (int i = 0; i < IN_W; i++) begin
            exact = exact + AB_W'(pc_in[i]);
        end
        approx  = AB_W'(pc_out);
        abs_err = (approx >= exact) ? (approx - exact) : (exact - approx);
        err_sum = {1'b0, err_q} + 17'(abs_err);
    end

    // Saturating error accumulator, updated on each popcount sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (state == ST_POS || state == ST_NEG) begin
            err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_acc = err_q;
`else
    assign err_acc = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tnn_popcount_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_popcount_sched
// Description : Directed self-checking bench for tnn_popcount_sched. The
//               popcount unit is modelled as an exact count plus a per-phase
//               offset, so that the error statistics can be exercised.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tnn_popcount_sched;

    localparam int NUM_REQ = 4;
    localparam int IN_W    = 29;
    localparam int CNT_W   = 5;
    localparam int THR_W   = 5;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*IN_W-1:0]   req_pos = '0;
    logic [NUM_REQ*IN_W-1:0]   req_neg = '0;
    logic [NUM_REQ*THR_W-1:0]  req_thr = '0;
    logic [IN_W-1:0]           pc_in;
    logic [CNT_W-1:0]          pc_out;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b1;
    logic [ID_W-1:0]           rsp_id;
    logic signed [CNT_W:0]     rsp_diff;
    logic [1:0]                rsp_act;
    logic [15:0]               err_acc;

    int n_tests = 0;
    int n_fail  = 0;

    int              pos_off = 0;
    int              neg_off = 0;
    logic [IN_W-1:0] cur_pos = '0;

    tnn_popcount_sched #(
        .NUM_REQ (NUM_REQ),
        .IN_W    (IN_W),
        .CNT_W   (CNT_W),
        .THR_W   (THR_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pos   (req_pos),
        .req_neg   (req_neg),
        .req_thr   (req_thr),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_diff  (rsp_diff),
        .rsp_act   (rsp_act),
        .err_acc   (err_acc)
    );

    always #5 clk = ~clk;

    // Approximate popcount unit: exact count plus phase offset, clamped to 0..31
    always_comb begin
        int e;
        e = $countones(pc_in) + ((pc_in == cur_pos) ? pos_off : neg_off);
        if (e < 0)  e = 0;
        if (e > 31) e = 31;
        pc_out = CNT_W'(e);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [IN_W-1:0] pos,
                           input logic [IN_W-1:0] neg, input logic [THR_W-1:0] thr);
        req_pos[id*IN_W +: IN_W]   = pos;
        req_neg[id*IN_W +: IN_W]   = neg;
        req_thr[id*THR_W +: THR_W] = thr;
        req_valid[id]              = 1'b1;
    endtask

    // Called just after a negedge; returns just after the negedge on which req_ready is seen
    task automatic wait_grant(input string tag, input logic [NUM_REQ-1:0] exp);
        int t;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq(tag, 32'(req_ready), 32'(exp));
    endtask

    // Full job with rsp_ready high; starts and ends at a negedge with the DUT in IDLE
    task automatic run_job(input string tag, input int id, input logic [IN_W-1:0] pos,
                           input logic [IN_W-1:0] neg, input logic [THR_W-1:0] thr,
                           input logic signed [CNT_W:0] exp_diff, input logic [1:0] exp_act);
        cur_pos   = pos;
        rsp_ready = 1'b1;
        set_req(id, pos, neg, thr);
        wait_grant({tag, ".grant"}, NUM_REQ'(1) << id);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        check_eq({tag, ".pc_pos"}, 32'(pc_in), 32'(pos));
        @(negedge clk);
        check_eq({tag, ".pc_neg"}, 32'(pc_in), 32'(neg));
        @(negedge clk);
        check_eq({tag, ".early_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, ".id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, ".diff"}, 32'(rsp_diff), 32'(exp_diff));
        check_eq({tag, ".act"}, 32'(rsp_act), 32'(exp_act));
        @(negedge clk);
        check_eq({tag, ".drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] grants [$];
        logic [ID_W-1:0]        s_id;
        logic signed [CNT_W:0]  s_diff;
        logic [1:0]             s_act;
        bit                     bad;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.req_ready", 32'(req_ready), 32'd0);
        check_eq("rst.pc_in", 32'(pc_in), 32'd0);
        check_eq("rst.rsp_diff", 32'(rsp_diff), 32'd0);
        check_eq("rst.err_acc", 32'(err_acc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job and threshold band
        run_job("t1", 0, 29'h000FFFFF, 29'h0000001F, 5'd10, 6'sd15, 2'b01);
        run_job("t2a", 1, 29'h0000007F, 29'h000001FF, 5'd3, -6'sd2, 2'b00);
        run_job("t2b", 3, 29'h0000007F, 29'h000001FF, 5'd2, -6'sd2, 2'b11);
        run_job("t2c", 2, 29'h00000003, 29'h00000003, 5'd0, 6'sd0, 2'b01);

        // Reset in NEG: leaves rr at 3 beforehand, must come back at 0
        cur_pos = 29'h0000FFFF;
        set_req(2, 29'h0000FFFF, 29'h0000000F, 5'd1);
        wait_grant("t5.grant", 4'b0100);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t5.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5.pc_in", 32'(pc_in), 32'd0);
        check_eq("t5.rsp_id", 32'(rsp_id), 32'd0);
        check_eq("t5.rsp_act", 32'(rsp_act), 32'd0);
        check_eq("t5.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) bad = 1'b1;
        end
        check_eq("t5.no_rsp", 32'(bad), 32'd0);

        // Fairness: all requesters valid continuously
        for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, 5'd0);
        cur_pos   = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req_ready != '0) grants.push_back(req_ready);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (8) @(negedge clk);
        check_eq("t3.count", 32'(grants.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            check_eq($sformatf("t3.grant%0d", i), 32'(grants[i]), 32'(NUM_REQ'(1) << (i % 4)));

        // Backpressure
        cur_pos   = 29'h000000FF;
        rsp_ready = 1'b0;
        set_req(1, 29'h000000FF, 29'h00000003, 5'd4);
        wait_grant("t4.grant", 4'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(3, 29'h00000001, 29'h00000001, 5'd0);
        repeat (3) @(negedge clk);
        check_eq("t4.valid", 32'(rsp_valid), 32'd1);
        check_eq("t4.diff", 32'(rsp_diff), 32'(6'sd6));
        check_eq("t4.act", 32'(rsp_act), 32'd1);
        s_id = rsp_id; s_diff = rsp_diff; s_act = rsp_act;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || rsp_id != s_id || rsp_diff != s_diff || rsp_act != s_act) bad = 1'b1;
            if (req_ready != '0) bad = 1'b1;
        end
        check_eq("t4.hold", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t4.release", 32'(rsp_valid), 32'd0);
        check_eq("t4.next_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Error statistics: +3 on pos, -2 on neg
        pos_off = 3;
        neg_off = -2;
`ifdef TNN_SCHED_ERRSTAT_EN
        check_eq("t6.err_before", 32'(err_acc), 32'd0);
        run_job("t6", 0, 29'h000003FF, 29'h0000000F, 5'd5, 6'sd11, 2'b01);
        check_eq("t6.err_after", 32'(err_acc), 32'd5);
        cur_pos = '0;
        pos_off = 31;
        neg_off = 31;
        set_req(0, '0, '0, 5'd0);
        repeat (1100 * 5 + 20) @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);
        check_eq("t6.saturate", 32'(err_acc), 32'h0000FFFF);
`else
        run_job("t6", 0, 29'h000003FF, 29'h0000000F, 5'd5, 6'sd11, 2'b01);
        check_eq("t6.err_zero", 32'(err_acc), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
